// File: rtl/axis_uart_tx_feeder.sv
// Synchronous FIFO: DEPTH entries of WIDTH bits, head word visible combinationally.
// Latency: a pushed word is visible at rdata/level on the cycle after the push edge.
// Backpressure: full blocks pushes and empty blocks pops; both are decoded from the registered count.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [LW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_LEVEL);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];
  assign level   = count;

  // Storage array; no reset needed because the count masks stale words.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= wdata;
    end
  end

  // Pointers wrap naturally; count tracks occupancy so full and empty are distinct.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + 1'b1;
      end
      if (do_pop) begin
        rptr <= rptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end
endmodule

// AXI-Stream byte buffer feeding uart_tx one byte at a time and flagging end of frame.
// Latency: 2 cycles from an accepted beat into an idle block to tx_start; 1 cycle from tx_done to the next tx_start.
// Backpressure: s_axis_tready drops only when the FIFO holds FIFO_DEPTH entries; a pop in the same cycle does not reopen it.
module axis_uart_tx_feeder #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  output logic                          tx_start,
  output logic [7:0]                    tx_data,
  input  logic                          tx_done,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          frame_done
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  logic [1:0] state;
  logic [1:0] next_state;
  logic [8:0] head;
  logic       full;
  logic       empty;
  logic       pop;
  logic       push;
  logic       cur_last;

  assign push          = s_axis_tvalid && s_axis_tready;
  assign s_axis_tready = !full;
  assign busy          = (state != IDLE);

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (9)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({s_axis_tlast, s_axis_tdata}),
    .pop   (pop),
    .rdata (head),
    .level (fifo_level),
    .full  (full),
    .empty (empty)
  );

  // Next-state and pop decode: a byte leaves the FIFO on every transition into START.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          next_state = START;
          pop        = 1'b1;
        end
      end
      START: begin
        next_state = WAIT;
      end
      WAIT: begin
        if (tx_done) begin
          if (!empty) begin
            next_state = START;
            pop        = 1'b1;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State register plus registered strobes so tx_start and frame_done are glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tx_start   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= next_state;
      tx_start   <= (next_state == START);
      frame_done <= (state == WAIT) && tx_done && cur_last;
    end
  end

  // Latch the popped byte; it is held until the next pop so uart_tx sees a stable value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_data  <= 8'h00;
      cur_last <= 1'b0;
    end else if (pop) begin
      tx_data  <= head[7:0];
      cur_last <= head[8];
    end
  end
endmodule

// File: tb/tb_axis_uart_tx_feeder.sv
// Randomised bench for axis_uart_tx_feeder with a timing-rule reference model and event scoreboard.
// Expected tx_start/frame_done events are queued at push time and popped by an independent monitor.
// The bench plays uart_tx, answering each predicted start with tx_done after a chosen delay.
module tb_axis_uart_tx_feeder;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int MAXE  = 1024;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    s_axis_tdata = 8'h00;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tready;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          tx_done = 1'b0;
  logic          busy;
  logic [LW-1:0] fifo_level;
  logic          frame_done;

  axis_uart_tx_feeder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .tx_start      (tx_start),
    .tx_data       (tx_data),
    .tx_done       (tx_done),
    .busy          (busy),
    .fifo_level    (fifo_level),
    .frame_done    (frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Reference model: per accepted byte, its accept cycle, start cycle and done cycle.
  int         acc [MAXE];
  int         st  [MAXE];
  int         dn  [MAXE];
  logic [7:0] dat [MAXE];
  int nb = 0;
  int ne = 0;
  int prev_done = -100;
  int dmin = 20;
  int dmax = 20;
  int spur_pct = 0;

  typedef struct { int c; logic [7:0] d; } ev_t;
  ev_t start_q[$];
  int  fd_q[$];

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @cyc %0d: got 'h%0h, expected 'h%0h", nm, cyc, act, exp);
    end
  endtask

  // A byte sits in the FIFO from the cycle after acceptance up to the cycle before its start.
  function automatic int m_level(input int c);
    int k = 0;
    for (int n = nb; n < ne; n++) if (acc[n] < c && st[n] - 1 >= c) k++;
    return k;
  endfunction

  function automatic logic m_busy(input int c);
    logic b = 1'b0;
    for (int n = nb; n < ne; n++) if (st[n] <= c && c <= dn[n]) b = 1'b1;
    return b;
  endfunction

  function automatic logic [7:0] m_txd(input int c);
    logic [7:0] r = 8'h00;
    for (int n = nb; n < ne; n++) if (st[n] <= c) r = dat[n];
    return r;
  endfunction

  // Drive one cycle of inputs, update the model on acceptance, advance to the next cycle.
  task automatic step(input logic v, input logic [7:0] d, input logic l, output logic took);
    int   c = cyc;
    logic real_done = 1'b0;
    logic allow = 1'b1;
    int   s;
    for (int n = nb; n < ne; n++) begin
      if (dn[n] == c) real_done = 1'b1;
      if (c > st[n] && c <= dn[n]) allow = 1'b0;
    end
    tx_done = real_done || (allow && !rst && ($urandom_range(0, 99) < spur_pct));
    s_axis_tvalid = v;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    took = v && !rst && (m_level(c) != DEPTH);
    if (took) begin
      s = (c + 2 > prev_done + 1) ? c + 2 : prev_done + 1;
      acc[ne] = c;
      dat[ne] = d;
      st[ne]  = s;
      dn[ne]  = s + $urandom_range(dmin, dmax);
      prev_done = dn[ne];
      start_q.push_back('{c: s, d: d});
      if (l) fd_q.push_back(dn[ne] + 1);
      ne++;
    end
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    tx_done = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] d, input logic l);
    logic t = 1'b0;
    int   guard = 0;
    while (!t) begin
      step(1'b1, d, l, t);
      guard++;
      if (guard > 500) begin
        nerr++;
        $display("FAIL push_timeout @cyc %0d: byte 'h%0h never accepted, expected acceptance", cyc, d);
        break;
      end
    end
  endtask

  task automatic idle_until(input int c_end);
    logic t;
    while (cyc < c_end) step(1'b0, 8'h00, 1'b0, t);
  endtask

  task automatic drain();
    idle_until((ne > nb) ? dn[ne-1] + 3 : cyc + 3);
  endtask

  // Monitor: per-cycle state checks and event scoreboard pops.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      chk("fifo_level", fifo_level, m_level(cyc));
      chk("s_axis_tready", s_axis_tready, m_level(cyc) != DEPTH);
      chk("busy", busy, m_busy(cyc));
      chk("tx_data", tx_data, m_txd(cyc));
      if (tx_start === 1'b1) begin
        if (start_q.size() == 0) chk("tx_start_unexpected", 1, 0);
        else begin
          e = start_q.pop_front();
          chk("tx_start_cycle", cyc, e.c);
          chk("tx_start_data", tx_data, e.d);
        end
      end else if (start_q.size() != 0 && start_q[0].c <= cyc) begin
        chk("tx_start_missing", 0, 1);
        void'(start_q.pop_front());
      end
      if (frame_done === 1'b1) begin
        if (fd_q.size() == 0) chk("frame_done_unexpected", 1, 0);
        else chk("frame_done_cycle", cyc, fd_q.pop_front());
      end else if (fd_q.size() != 0 && fd_q[0] <= cyc) begin
        chk("frame_done_missing", 0, 1);
        void'(fd_q.pop_front());
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog @cyc %0d: bench did not finish, expected completion", cyc);
    $fatal(1);
  end

  task automatic chk_reset_values(input string tag);
    chk({tag, "_tready"}, s_axis_tready, 1);
    chk({tag, "_tx_start"}, tx_start, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_fifo_level"}, fifo_level, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
  endtask

  initial begin
    int k;
    repeat (3) @(negedge clk);
    chk_reset_values("por");
    rst = 1'b0;

    // Single byte, with tx_done held high in every IDLE and START cycle as spurious noise.
    dmin = 20; dmax = 20; spur_pct = 100;
    idle_until(cyc + 3);
    push_byte(8'hA5, 1'b1);
    drain();
    spur_pct = 0;

    // Fill to full with tx_done withheld for a long time; 06 must wait on the bus.
    dmin = 40; dmax = 40;
    for (int b = 1; b <= 6; b++) push_byte(8'(b), 1'b0);
    drain();

    // Ordered stream with a 5-cycle UART response; one frame end on 1F.
    dmin = 5; dmax = 5;
    for (int b = 8'h10; b <= 8'h1F; b++) push_byte(8'(b), b == 8'h1F);
    drain();

    // Push landing exactly on the tx_done/pop cycle with two entries buffered.
    dmin = 8; dmax = 8;
    push_byte(8'h21, 1'b0);
    k = ne - 1;
    push_byte(8'h22, 1'b0);
    push_byte(8'h23, 1'b0);
    idle_until(dn[k]);
    chk("pre_simul_level", fifo_level, 2);
    push_byte(8'h24, 1'b1);
    chk("post_simul_level", fifo_level, 2);
    drain();

    // Asynchronous reset in WAIT with three bytes buffered.
    dmin = 30; dmax = 30;
    push_byte(8'h30, 1'b0);
    k = ne - 1;
    push_byte(8'h31, 1'b0);
    push_byte(8'h32, 1'b0);
    push_byte(8'h33, 1'b1);
    idle_until(st[k] + 3);
    chk("pre_reset_level", fifo_level, 3);
    #2 rst = 1'b1;
    #1;
    chk_reset_values("async");
    nb = ne;
    prev_done = -100;
    start_q.delete();
    fd_q.delete();
    idle_until(cyc + 2);
    rst = 1'b0;
    chk("post_reset_level", fifo_level, 0);
    dmin = 6; dmax = 6;
    push_byte(8'h5A, 1'b0);
    drain();

    // Random traffic: random gaps, data, tlast, UART delay and spurious tx_done.
    dmin = 1; dmax = 12; spur_pct = 25;
    for (int i = 0; i < 250; i++) begin
      idle_until(cyc + $urandom_range(0, 2));
      push_byte(8'($urandom), $urandom_range(0, 4) == 0);
    end
    spur_pct = 0;
    drain();

    chk("start_q_drained", start_q.size(), 0);
    chk("frame_q_drained", fd_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/axis_uart_tx_feeder.md
# axis_uart_tx_feeder

Upstream stage of the UART transmitter. It accepts bytes on an AXI-Stream slave port and buffers them in a synchronous FIFO. It hands the bytes one at a time to `uart_tx` through the `tx_start`/`tx_data`/`tx_done` handshake. It also reports FIFO occupancy and signals the end of each AXI-Stream frame, marked by `tlast`, once that frame's last byte has left the UART.

## Interface
- `FIFO_DEPTH`, default 16: number of byte entries; a power of two, ≥ 2.
- `clk` input 1: single clock for the whole block.
- `rst` input 1: reset; asynchronous, active-high.
- `s_axis_tdata` input 8: byte to transmit.
- `s_axis_tvalid` input 1: upstream has a valid byte.
- `s_axis_tready` output 1: block can accept a byte.
- `s_axis_tlast` input 1: the byte is the last byte of a frame.
- `tx_start` output 1: one-cycle request to `uart_tx`.
- `tx_data` output 8: byte presented to `uart_tx`.
- `tx_done` input 1: one-cycle pulse from `uart_tx` after the stop bit.
- `busy` output 1: high whenever the FSM is not in IDLE.
- `fifo_level` output $clog2(FIFO_DEPTH)+1: number of entries currently stored.
- `frame_done` output 1: one-cycle pulse when `tx_done` arrives for a byte that carried `tlast`.

## Operation
- Each FIFO entry is 9 bits: {tlast, tdata}.
- Write pointer and read pointer are $clog2(FIFO_DEPTH) bits and wrap naturally. The separate count `fifo_level` runs from 0 to FIFO_DEPTH.
- `s_axis_tready` = (fifo_level != FIFO_DEPTH). It is a combinational decode of the registered count only and has no dependence on a read in the same cycle.
- A push happens when `s_axis_tvalid` && `s_axis_tready`.
- A pop happens only as an FSM action, described below.
- Simultaneous push and pop leave `fifo_level` unchanged. When the FIFO is full, no push can occur, because tready is 0, even if a pop happens in the same cycle.
- The FSM has three states: IDLE, START and WAIT.
  - IDLE: if fifo_level != 0, pop the head entry into `tx_data` and the cur_last register, then go to START.
  - START: `tx_start` = 1 for exactly this one cycle, then go to WAIT unconditionally.
  - WAIT: hold `tx_data`. On `tx_done`, pulse `frame_done` if cur_last = 1. Then, if fifo_level != 0, pop the next entry and go to START; otherwise go to IDLE.
- `tx_start` and `frame_done` are registered and are decodes of the state and flags.
- `tx_done` is ignored in IDLE and in START.
- `tx_data` is stable from the START cycle through the `tx_done` cycle. It keeps its last value while idle.
- Reset mid-operation, whether in START or WAIT and whether the FIFO is full or partly full:
  - state returns to IDLE;
  - pointers and count clear, so buffered data is discarded;
  - all outputs take their reset values.
- Reset values: `s_axis_tready` = 1, `tx_start` = 0, `tx_data` = 8'h00, `busy` = 0, `fifo_level` = 0, `frame_done` = 0.

## Timing
- Push accepted on the edge closing cycle 0:
  - cycle 1: `fifo_level` = 1 and the FSM is in IDLE;
  - cycle 2: `tx_start` = 1 with `tx_data` valid.
- First-byte latency from the handshake to `tx_start` is therefore 2 cycles.
- Back-to-back bytes: with `tx_done` high in cycle k and the FIFO non-empty, `tx_start` is high in cycle k+1 with the new byte. There is no IDLE cycle between bytes.
- `frame_done` is high in cycle k+1 when `tx_done` in cycle k closes a tlast byte, i.e. concurrently with the next `tx_start` if one follows.
- `busy` rises in cycle 2 in the single-byte case. It falls in the cycle after the final `tx_done` when the FIFO is empty.
- Throughput is bounded by the UART: one byte per (10 × baud period + 1) cycles.

## Test plan
- Single byte: push 8'hA5 with tlast = 1 into an empty block, and model `tx_done` as a pulse 20 cycles after `tx_start`.
  - Required: `tx_start` 2 cycles after the handshake, `tx_data` = A5;
  - `frame_done` pulses 1 cycle after `tx_done`;
  - `busy` falls, and `fifo_level` reads 1 then 0.
- Fill to full: with FIFO_DEPTH = 4 and `tx_done` withheld, push 8'h01–8'h06 continuously.
  - Required: entry 01 pops into `tx_data`;
  - 02–05 fill the FIFO, so `fifo_level` = 4 and `s_axis_tready` = 0;
  - 06 is held on the bus, is not lost, and is accepted one cycle after the next pop.
- Ordering and gap: stream 8'h10–8'h1F with tlast on 8'h1F, and answer each `tx_start` with `tx_done` 5 cycles later.
  - Required: bytes leave in order;
  - each `tx_start` lands exactly 1 cycle after the preceding `tx_done`;
  - exactly one `frame_done` occurs, after 1F.
- Simultaneous push and pop: push a byte in the same cycle that `tx_done` triggers a pop, with fifo_level = 2. Required: `fifo_level` stays 2.
- Spurious `tx_done`: pulse `tx_done` while in IDLE and while in START. Required: no state change, no pop, no `frame_done`.
- Reset mid-transfer: assert `rst` asynchronously during WAIT with 3 bytes buffered.
  - Required: outputs go to their reset values immediately, without waiting for a clock edge;
  - after release, `fifo_level` = 0, and a new byte 8'h5A is delivered with the normal 2-cycle latency.
